// File: rtl/eeprom_page_reader.sv
// eeprom_page_reader: read-side byte serializer for the I2C EEPROM slave model.
// Shifts page bytes out MSB-first on SDA, samples the master ACK/NACK after each
// byte and auto-increments the byte pointer within the page.
// Optional feature macro: EEPROM_RD_WRAP_EN (pointer wraps to byte 0 after the last
// byte; without it the pointer holds, ovf is set and 0xFF is served).
module eeprom_page_reader #(
    parameter int BYTE_NUM  = 8,
    parameter int PTR_W     = $clog2(BYTE_NUM),
    localparam int PAGE_SIZE = BYTE_NUM * 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PTR_W-1:0]     start_ptr,
    input  logic [PAGE_SIZE-1:0] page_data,
    input  logic                 scl_rise,
    input  logic                 scl_fall,
    input  logic                 sda_in,
    input  logic                 stop,
    output logic                 sda_oe,
    output logic                 busy,
    output logic [PTR_W-1:0]     ptr,
    output logic                 done,
    output logic                 ovf
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_ACK     = 3'd3,
        ST_ACK_END = 3'd4
    } state_t;

`ifndef EEPROM_RD_WRAP_EN
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BYTE_NUM - 1);
`endif

    state_t             r_state;
    logic [6:0]         r_sreg;     // bits still to send after the one on SDA
    logic [2:0]         r_bit_cnt;
    logic               r_sda_oe;
    logic               r_busy;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_done;
    logic               r_ovf;

    logic [7:0]         w_page_byte;
    logic [7:0]         w_load_byte;
    logic               w_fall;
    logic               w_rise;

    assign w_page_byte = page_data[{r_ptr, 3'b000} +: 8];

    // A simultaneous rise/fall is a protocol error; the fall takes precedence.
    assign w_fall = scl_fall;
    assign w_rise = scl_rise & ~scl_fall;

    // Select the byte to load: page byte, or 0xFF once the read ran off the page.
    always_comb begin
        w_load_byte = w_page_byte;
`ifdef EEPROM_RD_WRAP_EN
        w_load_byte = w_page_byte;
`else
        if (r_ovf) begin
            w_load_byte = 8'hFF;
        end else begin
            w_load_byte = w_page_byte;
        end
`endif
    end

    // Read FSM: load, shift out MSB-first, handle master ACK/NACK, advance pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sreg    <= 7'h00;
            r_bit_cnt <= 3'd0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                // STOP / repeated START aborts any read and frees the bus.
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                        if (start) begin
                            r_ptr   <= start_ptr;
                            r_ovf   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_sreg    <= w_load_byte[6:0];
                        r_bit_cnt <= 3'd7;
                        r_sda_oe  <= ~w_load_byte[7];
                        r_state   <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_fall) begin
                            if (r_bit_cnt != 3'd0) begin
                                r_sda_oe  <= ~r_sreg[6];
                                r_sreg    <= {r_sreg[5:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end else begin
                                // Release SDA so the master can drive ACK/NACK.
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (w_rise) begin
                            if (!sda_in) begin
`ifdef EEPROM_RD_WRAP_EN
                                r_ptr <= r_ptr + PTR_W'(1);
                                r_ovf <= 1'b0;
`else
                                if (r_ptr == LAST_PTR) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_ptr <= r_ptr + PTR_W'(1);
                                end
`endif
                                r_state <= ST_ACK_END;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_ACK_END: begin
                        if (w_fall) begin
                            r_state <= ST_LOAD;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe = r_sda_oe;
    assign busy   = r_busy;
    assign ptr    = r_ptr;
    assign done   = r_done;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_eeprom_page_reader.sv
// Directed testbench for eeprom_page_reader: emulates the SCL strobes and the
// master ACK/NACK, reassembles bytes from sda_oe and checks against fixed values.
module tb_eeprom_page_reader;

    localparam logic [63:0] PAGE = 64'h8877665544332211;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  start_ptr;
    logic [63:0] page_data;
    logic        scl_rise;
    logic        scl_fall;
    logic        sda_in;
    logic        stop;
    logic        sda_oe;
    logic        busy;
    logic [2:0]  ptr;
    logic        done;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] b_early;
    logic [7:0] b_late;
    logic       done_r;
    logic       busy_r;

    eeprom_page_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_ptr (start_ptr),
        .page_data (page_data),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_in    (sda_in),
        .stop      (stop),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .ptr       (ptr),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start pulse, then the LOAD cycle; afterwards bit 7 is on sda_oe.
    task automatic do_start(input logic [2:0] p);
        start = 1'b1;
        start_ptr = p;
        cyc();
        start = 1'b0;
        start_ptr = 3'd0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("oe_in_load", {63'd0, sda_oe}, 64'd0);
        cyc();
    endtask

    // One SCL bit period: 2 low cycles, rise, 1 high cycle, fall.
    task automatic clock_bits(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            cyc();
            scl_rise = 1'b1; cyc(); scl_rise = 1'b0;
            cyc();
            scl_fall = 1'b1; cyc(); scl_fall = 1'b0;
        end
    endtask

    // Read one byte as the master; b_early is sampled 1 cycle after each edge
    // that should update SDA, b_late just before the rise strobe.
    task automatic read_byte(input logic nack, input int glitch_bit,
                             output logic [7:0] be, output logic [7:0] bl,
                             output logic dr, output logic br);
        for (int i = 7; i >= 0; i--) begin
            be[i] = ~sda_oe;
            if (i == glitch_bit) begin
                start = 1'b1;
                start_ptr = 3'd5;
            end
            cyc();
            start = 1'b0;
            start_ptr = 3'd0;
            cyc();
            bl[i] = ~sda_oe;
            scl_rise = 1'b1; cyc(); scl_rise = 1'b0;
            cyc();
            scl_fall = 1'b1; cyc(); scl_fall = 1'b0;
        end
        check("sda_release", {63'd0, sda_oe}, 64'd0);
        sda_in = nack;
        cyc();
        cyc();
        scl_rise = 1'b1; cyc(); scl_rise = 1'b0;
        dr = done;
        br = busy;
        sda_in = 1'b1;
        cyc();
        if (!nack) begin
            scl_fall = 1'b1; cyc(); scl_fall = 1'b0;
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_ptr = 3'd0; page_data = PAGE;
        scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b1; stop = 1'b0;
        cyc();
        cyc();
        check("rst_sda_oe", {63'd0, sda_oe}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ptr", {61'd0, ptr}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        reset = 1'b0;
        cyc();

        // Sequential read from byte 0: ACK three bytes, NACK the fourth.
        do_start(3'd0);
        read_byte(1'b0, -1, b_early, b_late, done_r, busy_r);
        check("t1_b0", {56'd0, b_early}, 64'h11);
        check("t1_b0_late", {56'd0, b_late}, 64'h11);
        check("t1_done0", {63'd0, done_r}, 64'd0);
        check("t1_ptr1", {61'd0, ptr}, 64'd1);
        read_byte(1'b0, -1, b_early, b_late, done_r, busy_r);
        check("t1_b1", {56'd0, b_early}, 64'h22);
        check("t1_ptr2", {61'd0, ptr}, 64'd2);
        read_byte(1'b0, -1, b_early, b_late, done_r, busy_r);
        check("t1_b2", {56'd0, b_early}, 64'h33);
        read_byte(1'b1, -1, b_early, b_late, done_r, busy_r);
        check("t1_b3", {56'd0, b_early}, 64'h44);
        check("t1_done_nack", {63'd0, done_r}, 64'd1);
        check("t1_busy_nack", {63'd0, busy_r}, 64'd0);
        check("t1_done_clr", {63'd0, done}, 64'd0);
        check("t1_ptr_hold", {61'd0, ptr}, 64'd3);

        // Read across the end of the page starting at byte 6.
        do_start(3'd6);
        read_byte(1'b0, -1, b_early, b_late, done_r, busy_r);
        check("t2_b0", {56'd0, b_early}, 64'h77);
        check("t2_ovf0", {63'd0, ovf}, 64'd0);
        check("t2_ptr7", {61'd0, ptr}, 64'd7);
        read_byte(1'b0, -1, b_early, b_late, done_r, busy_r);
        check("t2_b1", {56'd0, b_early}, 64'h88);
`ifdef EEPROM_RD_WRAP_EN
        check("t2_ovf1", {63'd0, ovf}, 64'd0);
        check("t2_ptr_wrap", {61'd0, ptr}, 64'd0);
        read_byte(1'b0, -1, b_early, b_late, done_r, busy_r);
        check("t2_b2", {56'd0, b_early}, 64'h11);
        read_byte(1'b1, -1, b_early, b_late, done_r, busy_r);
        check("t2_b3", {56'd0, b_early}, 64'h22);
        check("t2_ovf_end", {63'd0, ovf}, 64'd0);
`else
        check("t2_ovf1", {63'd0, ovf}, 64'd1);
        check("t2_ptr_hold", {61'd0, ptr}, 64'd7);
        read_byte(1'b0, -1, b_early, b_late, done_r, busy_r);
        check("t2_b2", {56'd0, b_early}, 64'hFF);
        read_byte(1'b1, -1, b_early, b_late, done_r, busy_r);
        check("t2_b3", {56'd0, b_early}, 64'hFF);
        check("t2_ovf_end", {63'd0, ovf}, 64'd1);
`endif
        check("t2_done", {63'd0, done_r}, 64'd1);

        // STOP after bit 4 of 0x55 (bit 3 = 0 is on SDA when STOP arrives).
        do_start(3'd4);
        check("t3_ovf_clr", {63'd0, ovf}, 64'd0);
        clock_bits(4);
        check("t3_oe_before_stop", {63'd0, sda_oe}, 64'd1);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("t3_oe_stop", {63'd0, sda_oe}, 64'd0);
        check("t3_busy_stop", {63'd0, busy}, 64'd0);
        check("t3_done_stop", {63'd0, done}, 64'd0);
        cyc();
        check("t3_done_after", {63'd0, done}, 64'd0);
        do_start(3'd0);
        read_byte(1'b1, -1, b_early, b_late, done_r, busy_r);
        check("t3_b_after_stop", {56'd0, b_early}, 64'h11);

        // Reset while waiting for the ACK of byte 1.
        do_start(3'd1);
        clock_bits(8);
        check("t4_busy_ack", {63'd0, busy}, 64'd1);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("t4_sda_oe", {63'd0, sda_oe}, 64'd0);
        check("t4_busy", {63'd0, busy}, 64'd0);
        check("t4_ptr", {61'd0, ptr}, 64'd0);
        check("t4_done", {63'd0, done}, 64'd0);
        check("t4_ovf", {63'd0, ovf}, 64'd0);
        cyc();
        do_start(3'd2);
        read_byte(1'b1, -1, b_early, b_late, done_r, busy_r);
        check("t4_b_after_rst", {56'd0, b_early}, 64'h33);

        // 0xA5 bit pattern, sampled exactly 1 cycle after each update edge.
        page_data = 64'h88776655443322A5;
        cyc();
        do_start(3'd0);
        read_byte(1'b1, -1, b_early, b_late, done_r, busy_r);
        check("t5_a5_timing", {56'd0, b_early}, 64'hA5);
        check("t5_a5_late", {56'd0, b_late}, 64'hA5);
        page_data = PAGE;
        cyc();

        // start pulse during SHIFT must be ignored.
        do_start(3'd3);
        read_byte(1'b1, 5, b_early, b_late, done_r, busy_r);
        check("t6_byte", {56'd0, b_early}, 64'h44);
        check("t6_ptr", {61'd0, ptr}, 64'd3);
        check("t6_done", {63'd0, done_r}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
